// File: rtl/filter_cc_coeff_slew_if.sv
// Bus between the CC decoder / coefficient tables and filter_cc_coeff_slew.
// slave  : the slew block (consumes CCs, ticks and table words; drives
//          table addresses, slewed coefficients and status).
// master : the surrounding logic (CC decoder, sample timer, tables).
interface filter_cc_coeff_slew_if;
   localparam int unsigned CC_W   = 7;
   localparam int unsigned COEF_W = 18;

   logic                     cc_valid;
   logic [CC_W-1:0]          cc_num;
   logic [CC_W-1:0]          cc_value;
   logic                     sample_tick;
   logic [CC_W-1:0]          f_val;
   logic [CC_W-1:0]          q_val;
   logic signed [COEF_W-1:0] f_result;
   logic signed [COEF_W-1:0] q_result;
   logic signed [COEF_W-1:0] f_coeff;
   logic signed [COEF_W-1:0] q1_coeff;
   logic                     coeff_update;
   logic                     busy;

   modport master (
      output cc_valid, cc_num, cc_value, sample_tick, f_result, q_result,
      input  f_val, q_val, f_coeff, q1_coeff, coeff_update, busy
   );

   modport slave (
      input  cc_valid, cc_num, cc_value, sample_tick, f_result, q_result,
      output f_val, q_val, f_coeff, q1_coeff, coeff_update, busy
   );
endinterface

// File: rtl/filter_cc_coeff_slew.sv
// Filter coefficient slew block.
// Captures cutoff/resonance CCs into table addresses, collects the table
// words two edges later, and slews f_coeff/q1_coeff toward them once per
// audio sample tick.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : cc_valid/cc_num/cc_value, sample_tick, f_result/q_result in;
//                 f_val/q_val, f_coeff/q1_coeff, coeff_update, busy out
module filter_cc_coeff_slew #(
   parameter int unsigned        CUTOFF_CC   = 74,
   parameter int unsigned        RESO_CC     = 71,
   parameter int unsigned        INIT_CUTOFF = 127,
   parameter int unsigned        INIT_RESO   = 0,
   parameter logic signed [17:0] F_INIT      = 18'sh00000,
   parameter logic signed [17:0] Q_INIT      = 18'sh00000,
   parameter int unsigned        SLEW_SHIFT  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   filter_cc_coeff_slew_if.slave bus
);
   localparam int unsigned CC_W   = 7;
   localparam int unsigned COEF_W = 18;
   localparam int unsigned DIFF_W = COEF_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

   state_t                   state;
   logic [CC_W-1:0]          f_val_r;
   logic [CC_W-1:0]          q_val_r;
   logic signed [COEF_W-1:0] f_target;
   logic signed [COEF_W-1:0] q_target;
   logic signed [COEF_W-1:0] f_coeff_r;
   logic signed [COEF_W-1:0] q_coeff_r;
   logic signed [COEF_W-1:0] f_next;
   logic signed [COEF_W-1:0] q_next;
   logic                     coeff_update_r;
   logic                     busy_r;
   logic                     cut_hit;
   logic                     reso_hit;
   logic                     cc_accept;

   // One slew step: diff >>> SLEW_SHIFT, forced to +/-1 when it rounds to 0.
   function automatic logic signed [COEF_W-1:0] slew_step(
      input logic signed [COEF_W-1:0] coeff,
      input logic signed [COEF_W-1:0] target
   );
      logic signed [DIFF_W-1:0] diff;
      logic signed [DIFF_W-1:0] step;
      logic signed [DIFF_W-1:0] sum;
      diff = DIFF_W'(target) - DIFF_W'(coeff);
      step = diff >>> SLEW_SHIFT;
      if (diff == '0)
         step = '0;
      else if (step == '0)
         step = diff[DIFF_W-1] ? {DIFF_W{1'b1}} : DIFF_W'(1);
      sum = DIFF_W'(coeff) + step;
      return COEF_W'(sum);
   endfunction

   assign cut_hit   = bus.cc_valid && (bus.cc_num == CC_W'(CUTOFF_CC));
   assign reso_hit  = bus.cc_valid && (bus.cc_num == CC_W'(RESO_CC));
   assign cc_accept = cut_hit || reso_hit;

   // Candidate coefficients for the next sample tick.
   always_comb begin
      f_next = slew_step(f_coeff_r, f_target);
      q_next = slew_step(q_coeff_r, q_target);
   end

   // Lookup sequencing, target capture and per-tick slew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= WAIT;
         busy_r         <= 1'b1;
         f_val_r        <= CC_W'(INIT_CUTOFF);
         q_val_r        <= CC_W'(INIT_RESO);
         f_target       <= F_INIT;
         q_target       <= Q_INIT;
         f_coeff_r      <= F_INIT;
         q_coeff_r      <= Q_INIT;
         coeff_update_r <= 1'b0;
      end else begin
         coeff_update_r <= 1'b0;

         // A new CC restarts the lookup so a stale table word is never taken.
         if (cc_accept) begin
            if (cut_hit)
               f_val_r <= bus.cc_value;
            if (reso_hit)
               q_val_r <= bus.cc_value;
            state  <= WAIT;
            busy_r <= 1'b1;
         end else begin
            case (state)
               IDLE: busy_r <= 1'b0;
               WAIT: begin
                  state  <= CAPT;
                  busy_r <= 1'b1;
               end
               CAPT: begin
                  f_target <= bus.f_result;
                  q_target <= bus.q_result;
                  state    <= IDLE;
                  busy_r   <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            endcase
         end

         // Slew uses the pre-capture target when a tick lands on CAPT.
         if (bus.sample_tick) begin
            f_coeff_r      <= f_next;
            q_coeff_r      <= q_next;
            coeff_update_r <= (f_next != f_coeff_r) || (q_next != q_coeff_r);
         end
      end
   end

   assign bus.f_val        = f_val_r;
   assign bus.q_val        = q_val_r;
   assign bus.f_coeff      = f_coeff_r;
   assign bus.q1_coeff     = q_coeff_r;
   assign bus.coeff_update = coeff_update_r;
   assign bus.busy         = busy_r;
endmodule

// File: tb/tb_filter_cc_coeff_slew.sv
// Bench for filter_cc_coeff_slew: two instances (SLEW_SHIFT 4 and 0) share
// one stimulus stream; a latency-rule reference model predicts each edge's
// outputs into per-instance queues that a negedge monitor drains.
module tb_filter_cc_coeff_slew;
   logic clk;
   logic rst_n;

   filter_cc_coeff_slew_if ifc0 ();
   filter_cc_coeff_slew_if ifc1 ();

   filter_cc_coeff_slew #(.SLEW_SHIFT(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc0.slave)
   );

   filter_cc_coeff_slew #(.SLEW_SHIFT(0)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Coefficient tables: entry i = i*1000, one-clock registered latency.
   always @(posedge clk) begin
      ifc0.f_result <= 18'(int'(ifc0.f_val) * 1000);
      ifc0.q_result <= 18'(int'(ifc0.q_val) * 1000);
      ifc1.f_result <= 18'(int'(ifc1.f_val) * 1000);
      ifc1.q_result <= 18'(int'(ifc1.q_val) * 1000);
   end

   typedef struct {
      int fv;
      int qv;
      int fc;
      int qc;
      bit upd;
      bit busy;
   } obs_t;

   int   n_vec  = 0;
   int   n_fail = 0;
   obs_t exp0[$];
   obs_t exp1[$];

   // Reference model state per instance.
   int m_fa[2];
   int m_qa[2];
   int m_ft[2];
   int m_qt[2];
   int m_fc[2];
   int m_qc[2];
   int m_pend[2];
   bit m_upd[2];
   int m_sh[2];

   function automatic int slew(input int c, input int t, input int sh);
      int d;
      int s;
      d = t - c;
      if (d == 0) return c;
      s = d >>> sh;
      if (s == 0) s = (d > 0) ? 1 : -1;
      return c + s;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_fa[m]   = 127;
         m_qa[m]   = 0;
         m_ft[m]   = 0;
         m_qt[m]   = 0;
         m_fc[m]   = 0;
         m_qc[m]   = 0;
         m_pend[m] = 2;   // initial lookup lands two edges after release
         m_upd[m]  = 1'b0;
      end
   endtask

   function automatic obs_t model_obs(input int m);
      obs_t o;
      o.fv   = m_fa[m];
      o.qv   = m_qa[m];
      o.fc   = m_fc[m];
      o.qc   = m_qc[m];
      o.upd  = m_upd[m];
      o.busy = (m_pend[m] > 0);
      return o;
   endfunction

   function automatic obs_t dut_obs(input int m);
      obs_t o;
      if (m == 0) begin
         o.fv = int'(ifc0.f_val);   o.qv = int'(ifc0.q_val);
         o.fc = int'(ifc0.f_coeff); o.qc = int'(ifc0.q1_coeff);
         o.upd = ifc0.coeff_update; o.busy = ifc0.busy;
      end else begin
         o.fv = int'(ifc1.f_val);   o.qv = int'(ifc1.q_val);
         o.fc = int'(ifc1.f_coeff); o.qc = int'(ifc1.q1_coeff);
         o.upd = ifc1.coeff_update; o.busy = ifc1.busy;
      end
      return o;
   endfunction

   task automatic cmp_obs(input string name, input obs_t got, input obs_t want);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s t=%0t got fv=%0d qv=%0d fc=%0d qc=%0d upd=%0d busy=%0d want fv=%0d qv=%0d fc=%0d qc=%0d upd=%0d busy=%0d",
                  name, $time, got.fv, got.qv, got.fc, got.qc, got.upd, got.busy,
                  want.fv, want.qv, want.fc, want.qc, want.upd, want.busy);
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
      end
   endtask

   // Monitor: every predicted edge is compared half a clock later.
   always @(negedge clk) begin
      if (exp0.size() > 0) cmp_obs("edge_out0", dut_obs(0), exp0.pop_front());
      if (exp1.size() > 0) cmp_obs("edge_out1", dut_obs(1), exp1.pop_front());
   end

   task automatic drive(input bit cv, input int num, input int val, input bit tk);
      ifc0.cc_valid = cv; ifc0.cc_num = 7'(num); ifc0.cc_value = 7'(val); ifc0.sample_tick = tk;
      ifc1.cc_valid = cv; ifc1.cc_num = 7'(num); ifc1.cc_value = 7'(val); ifc1.sample_tick = tk;
   endtask

   // One clock edge: drive, clock, advance model, queue the expectation.
   task automatic step(input bit cv, input int num, input int val, input bit tk);
      bit acc;
      int nf;
      int nq;
      #1;
      drive(cv, num, val, tk);
      @(posedge clk);
      acc = cv && (num == 74 || num == 71);
      for (int m = 0; m < 2; m++) begin
         m_upd[m] = 1'b0;
         if (tk) begin
            nf = slew(m_fc[m], m_ft[m], m_sh[m]);
            nq = slew(m_qc[m], m_qt[m], m_sh[m]);
            m_upd[m] = (nf != m_fc[m]) || (nq != m_qc[m]);
            m_fc[m] = nf;
            m_qc[m] = nq;
         end
         if (acc) begin
            if (num == 74) m_fa[m] = val;
            else           m_qa[m] = val;
            m_pend[m] = 2;
         end else if (m_pend[m] > 0) begin
            m_pend[m]--;
            if (m_pend[m] == 0) begin
               m_ft[m] = m_fa[m] * 1000;
               m_qt[m] = m_qa[m] * 1000;
            end
         end
         if (m == 0) exp0.push_back(model_obs(0));
         else        exp1.push_back(model_obs(1));
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 0, 0, 1'b0);
         step(1'b0, 0, 0, 1'b0);
         step(1'b0, 0, 0, 1'b0);
         step(1'b0, 0, 0, 1'b1);
      end
   endtask

   task automatic random_steps(input int n);
      int r;
      int num;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 3));
         case (r)
            0:       num = 74;
            1:       num = 71;
            2:       num = 7;
            default: num = int'($urandom_range(0, 127));
         endcase
         step($urandom_range(0, 9) < 3, num, int'($urandom_range(0, 127)),
              $urandom_range(0, 2) == 0);
      end
   endtask

   initial begin
      m_sh[0] = 4;
      m_sh[1] = 0;
      model_reset();
      rst_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      cmp_obs("reset_state0", dut_obs(0), model_obs(0));
      cmp_obs("reset_state1", dut_obs(1), model_obs(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Initial lookup of the INIT addresses with no CC.
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("init_busy_low", int'(ifc0.busy), 0);
      chk("init_shift0_hit", int'(ifc1.f_coeff), 127000);

      run_ticks(220);
      @(negedge clk);
      chk("converge_127000", int'(ifc0.f_coeff), 127000);

      // CC74=64: first tick from 127000 steps by -3938.
      step(1'b1, 74, 64, 1'b0);
      @(negedge clk);
      chk("cc74_addr", int'(ifc0.f_val), 64);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("first_step", int'(ifc0.f_coeff), 127000 - 3938);
      chk("shift0_one_tick", int'(ifc1.f_coeff), 64000);
      run_ticks(220);
      @(negedge clk);
      chk("converge_64000", int'(ifc0.f_coeff), 64000);

      // Back-to-back CCs restart the lookup; then a resonance CC.
      step(1'b1, 74, 10, 1'b0);
      step(1'b1, 74, 20, 1'b0);
      step(1'b1, 71, 1, 1'b0);
      run_ticks(220);
      @(negedge clk);
      chk("restart_target", int'(ifc0.f_coeff), 20000);
      chk("reso_target", int'(ifc0.q1_coeff), 1000);

      // Tick on the capture edge uses the old target.
      step(1'b1, 74, 100, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("capt_tick_old", int'(ifc1.f_coeff), 20000);
      step(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("capt_tick_new", int'(ifc1.f_coeff), 100000);

      // Unrelated controller is ignored.
      step(1'b1, 7, 99, 1'b0);
      @(negedge clk);
      chk("other_cc_addr", int'(ifc0.f_val), 100);
      chk("other_cc_busy", int'(ifc0.busy), 0);

      random_steps(400);

      // Asynchronous reset mid-slew.
      step(1'b1, 74, 0, 1'b0);
      run_ticks(5);
      @(negedge clk);
      #1;
      drive(1'b0, 0, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp_obs("async_reset0", dut_obs(0), model_obs(0));
      cmp_obs("async_reset1", dut_obs(1), model_obs(1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      random_steps(300);

      for (int i = 0; i < 4 && (exp0.size() > 0 || exp1.size() > 0); i++)
         @(negedge clk);
      #1;
      chk("queue_drained", exp0.size() + exp1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
